// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate monitor for an encoder/channel/Viterbi loop: searches for the decoder
// latency against a tx history, then counts bits, errors and sync losses while locked.
`timescale 1ns/1ps
module viterbi_ber_checker #(
    parameter int DEPTH    = 32,
    parameter int SYNC_LEN = 16,
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8,
    parameter int CW       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_valid,
    input  logic                     tx_bit,
    input  logic                     rx_valid,
    input  logic                     rx_bit,
    input  logic                     clear,
    output logic                     locked,
    output logic [$clog2(DEPTH)-1:0] offset,
    output logic [CW-1:0]            bit_count,
    output logic [CW-1:0]            err_count,
    output logic [7:0]               loss_count,
    output logic                     sync_loss
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(SYNC_LEN + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int EW = $clog2(LOSS_THR + 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state;
    logic [DEPTH-1:0] hist;
    logic [AW-1:0]    wr_ptr;
    logic             fill;
    logic [RW-1:0]    match_run;
    logic [WW-1:0]    win_cnt;
    logic [EW-1:0]    win_err;

    logic [AW-1:0]    rd_idx_p0;
    logic             vld_p0;
    logic             mis_p0;

    function automatic logic [CW-1:0] sat_inc_cw(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0: compare the decoded bit against the pre-write history entry
    assign rd_idx_p0 = wr_ptr - AW'(1) - offset;
    assign vld_p0    = rx_valid & fill;
    assign mis_p0    = hist[rd_idx_p0] ^ rx_bit;

    // History holds data only; its contents after reset are irrelevant until refilled
    always_ff @(posedge clk) begin
        if (tx_valid) begin
            hist[wr_ptr] <= tx_bit;
        end
    end

    // Stage p1: registered alignment state and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SEARCH;
            wr_ptr     <= '0;
            fill       <= 1'b0;
            offset     <= '0;
            locked     <= 1'b0;
            bit_count  <= '0;
            err_count  <= '0;
            loss_count <= '0;
            match_run  <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
            sync_loss  <= 1'b0;
        end else begin
            sync_loss <= 1'b0;
            if (tx_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (wr_ptr == AW'(DEPTH - 1)) begin
                    fill <= 1'b1;
                end
            end
            if (vld_p0) begin
                case (state)
                    SEARCH: begin
                        if (mis_p0) begin
                            match_run <= '0;
                            offset    <= offset + AW'(1);
                        end else if (match_run == RW'(SYNC_LEN - 1)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_run <= '0;
                            win_cnt   <= '0;
                            win_err   <= '0;
                        end else begin
                            match_run <= match_run + RW'(1);
                        end
                    end
                    LOCKED: begin
                        bit_count <= sat_inc_cw(bit_count);
                        if (mis_p0) begin
                            err_count <= sat_inc_cw(err_count);
                        end
                        // Loss takes priority over a window rollover on the same compare
                        if (mis_p0 && (win_err == EW'(LOSS_THR - 1))) begin
                            state      <= SEARCH;
                            locked     <= 1'b0;
                            sync_loss  <= 1'b1;
                            loss_count <= sat_inc_8(loss_count);
                            match_run  <= '0;
                            offset     <= offset + AW'(1);
                            win_cnt    <= '0;
                            win_err    <= '0;
                        end else if (win_cnt == WW'(WIN - 1)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            win_err <= win_err + EW'(mis_p0);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
            if (clear) begin
                bit_count  <= '0;
                err_count  <= '0;
                loss_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Randomized bench for viterbi_ber_checker: a stream-level model tracks expected outputs
// every cycle; a CW=4 instance shares the stimulus to exercise counter saturation.
`timescale 1ns/1ps
module tb_viterbi_ber_checker;
    localparam int DEPTH    = 32;
    localparam int SYNC_LEN = 16;
    localparam int WIN      = 64;
    localparam int LOSS_THR = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic       tx_bit = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_bit = 1'b0;
    logic       clear = 1'b0;

    logic       locked, sync_loss;
    logic [4:0] offset;
    logic [15:0] bit_count, err_count;
    logic [7:0] loss_count;

    logic       locked4, sync_loss4;
    logic [4:0] offset4;
    logic [3:0] bit_count4, err_count4;
    logic [7:0] loss_count4;

    viterbi_ber_checker #(.DEPTH(DEPTH), .SYNC_LEN(SYNC_LEN), .WIN(WIN),
                          .LOSS_THR(LOSS_THR), .CW(16)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_bit(tx_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .clear(clear),
        .locked(locked), .offset(offset), .bit_count(bit_count),
        .err_count(err_count), .loss_count(loss_count), .sync_loss(sync_loss)
    );

    viterbi_ber_checker #(.DEPTH(DEPTH), .SYNC_LEN(SYNC_LEN), .WIN(WIN),
                          .LOSS_THR(LOSS_THR), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_bit(tx_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .clear(clear),
        .locked(locked4), .offset(offset4), .bit_count(bit_count4),
        .err_count(err_count4), .loss_count(loss_count4), .sync_loss(sync_loss4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: the complete tx stream plus the alignment/counting status
    bit txq[$];
    int delay;
    int m_off, m_run, m_wc, m_we, m_bits, m_errs, m_loss;
    bit m_locked, m_sync_loss;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        txq.delete();
        m_off = 0; m_run = 0; m_wc = 0; m_we = 0;
        m_bits = 0; m_errs = 0; m_loss = 0;
        m_locked = 0; m_sync_loss = 0;
    endtask

    task automatic compare_all();
        check_eq("locked",     64'(locked),      64'(m_locked));
        check_eq("offset",     64'(offset),      64'(m_off));
        check_eq("sync_loss",  64'(sync_loss),   64'(m_sync_loss));
        check_eq("bit_count",  64'(bit_count),   64'(sat(m_bits, 65535)));
        check_eq("err_count",  64'(err_count),   64'(sat(m_errs, 65535)));
        check_eq("loss_count", 64'(loss_count),  64'(sat(m_loss, 255)));
        check_eq("locked4",    64'(locked4),     64'(m_locked));
        check_eq("offset4",    64'(offset4),     64'(m_off));
        check_eq("bit_count4", 64'(bit_count4),  64'(sat(m_bits, 15)));
        check_eq("err_count4", 64'(err_count4),  64'(sat(m_errs, 15)));
        check_eq("loss_count4", 64'(loss_count4), 64'(sat(m_loss, 255)));
    endtask

    // One clock: drive stimulus, advance the model, then compare after the edge
    task automatic cycle(input bit txv, input bit rxv, input bit flip, input bit clr);
        int w;
        bit rb, tb, mis;
        w = txq.size();
        tb = 1'($urandom_range(0, 1));
        if (delay >= 0 && (w - 1 - delay) >= 0) rb = txq[w - 1 - delay];
        else rb = 1'($urandom_range(0, 1));
        rb = rb ^ flip;
        tx_valid = txv; tx_bit = tb; rx_valid = rxv; rx_bit = rb; clear = clr;

        m_sync_loss = 0;
        if (rxv && w >= DEPTH) begin
            mis = (txq[w - 1 - m_off] != rb);
            if (!m_locked) begin
                if (mis) begin
                    m_run = 0;
                    m_off = (m_off + 1) % DEPTH;
                end else begin
                    m_run++;
                    if (m_run == SYNC_LEN) begin
                        m_locked = 1; m_run = 0; m_wc = 0; m_we = 0;
                    end
                end
            end else begin
                m_bits++;
                m_wc++;
                if (mis) begin m_errs++; m_we++; end
                if (m_we == LOSS_THR) begin
                    m_locked = 0; m_sync_loss = 1; m_loss++; m_run = 0;
                    m_off = (m_off + 1) % DEPTH; m_wc = 0; m_we = 0;
                end else if (m_wc == WIN) begin
                    m_wc = 0; m_we = 0;
                end
            end
        end
        if (clr) begin m_bits = 0; m_errs = 0; m_loss = 0; end
        if (txv) txq.push_back(tb);

        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic apply_reset(input string tag);
        #3;
        rst = 1'b0;
        tx_valid = 0; rx_valid = 0; clear = 0;
        model_reset();
        #1;
        check_eq({tag, "_locked"},    64'(locked),     64'(0));
        check_eq({tag, "_offset"},    64'(offset),     64'(0));
        check_eq({tag, "_bits"},      64'(bit_count),  64'(0));
        check_eq({tag, "_errs"},      64'(err_count),  64'(0));
        check_eq({tag, "_loss"},      64'(loss_count), 64'(0));
        check_eq({tag, "_sync_loss"}, 64'(sync_loss),  64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic wait_lock(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (locked) break;
            cycle(1, 1, 0, 0);
        end
        check_eq({tag, "_lock_seen"}, 64'(locked), 64'(1));
    endtask

    initial begin
        int seen_lock, wraps, prev_off;
        delay = 9;
        apply_reset("init");

        // Clean lock at latency 9, then a long error-free run
        wait_lock("d9", 600);
        check_eq("d9_offset", 64'(offset), 64'(9));
        check_eq("d9_bits0", 64'(bit_count), 64'(0));
        repeat (1000) cycle(1, 1, 0, 0);
        check_eq("clean_bits", 64'(bit_count), 64'(1000));
        check_eq("clean_errs", 64'(err_count), 64'(0));
        check_eq("clean_loss", 64'(loss_count), 64'(0));

        // Two errors in one window are tolerated
        seen_lock = 0;
        cycle(1, 1, 1, 0);
        seen_lock += int'(sync_loss);
        cycle(1, 1, 1, 0);
        seen_lock += int'(sync_loss);
        for (int i = 0; i < 30; i++) begin
            cycle(1, 1, 0, 0);
            seen_lock += int'(sync_loss);
        end
        check_eq("sparse_errs", 64'(err_count), 64'(2));
        check_eq("sparse_locked", 64'(locked), 64'(1));
        check_eq("sparse_no_loss", 64'(seen_lock), 64'(0));

        // Eight errors in one window force a sync loss, then relock
        repeat (8) cycle(1, 1, 1, 0);
        check_eq("loss_pulse", 64'(sync_loss), 64'(1));
        check_eq("loss_unlocked", 64'(locked), 64'(0));
        check_eq("loss_count1", 64'(loss_count), 64'(1));
        check_eq("loss_errs", 64'(err_count), 64'(10));
        check_eq("loss_bits", 64'(bit_count), 64'(1040));
        check_eq("loss_offset", 64'(offset), 64'(10));
        cycle(1, 1, 0, 0);
        check_eq("loss_pulse_end", 64'(sync_loss), 64'(0));
        wait_lock("relock", 600);
        check_eq("relock_offset", 64'(offset), 64'(9));
        check_eq("relock_bits", 64'(bit_count), 64'(1040));

        // Reset in the middle of a locked, counting stream
        repeat (5) cycle(1, 1, 0, 0);
        apply_reset("mid");

        // Largest offset, reached by wrapping the search
        delay = 31;
        wait_lock("d31", 800);
        check_eq("d31_offset", 64'(offset), 64'(31));

        // Uncorrelated rx never locks and the offset keeps cycling
        apply_reset("rnd");
        delay = -1;
        seen_lock = 0; wraps = 0; prev_off = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 0, 0);
            seen_lock += int'(locked);
            if (prev_off == DEPTH - 1 && int'(offset) == 0) wraps++;
            prev_off = int'(offset);
        end
        check_eq("rnd_never_lock", 64'(seen_lock), 64'(0));
        check_eq("rnd_wrapped", 64'(wraps > 0), 64'(1));

        // Independent valids and occasional clears, latency 5
        delay = 5;
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 0,
                  $urandom_range(0, 49) == 0);
        end
        check_eq("d5_locked", 64'(locked), 64'(1));
        check_eq("d5_offset", 64'(offset), 64'(5));

        // One error per window: narrow counters saturate without losing sync
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, 1, 0);
            repeat (WIN - 1) cycle(1, 1, 0, 0);
        end
        check_eq("sat_errs4", 64'(err_count4), 64'(15));
        check_eq("sat_bits4", 64'(bit_count4), 64'(15));
        check_eq("sat_locked", 64'(locked4), 64'(1));

        // Clear beats the same-cycle increment and leaves lock intact
        cycle(1, 1, 0, 1);
        check_eq("clr_bits", 64'(bit_count), 64'(0));
        check_eq("clr_errs", 64'(err_count), 64'(0));
        check_eq("clr_loss", 64'(loss_count), 64'(0));
        check_eq("clr_bits4", 64'(bit_count4), 64'(0));
        check_eq("clr_errs4", 64'(err_count4), 64'(0));
        check_eq("clr_locked", 64'(locked), 64'(1));
        check_eq("clr_offset", 64'(offset), 64'(5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive-end bit-error-rate monitor for the encoder → channel → Viterbi decoder loop.
- Keeps a history of the bits fed into the convolutional encoder and finds the decoder's latency automatically by searching alignment offsets.
- Once aligned, compares every decoded bit against the transmitted bit and reports bit, error and sync-loss counts.
- Sits beside the decoder in the tx/rx harness. Its counters are the bench's pass/fail figure for decoder correction under injected channel errors.

Parameters:
- DEPTH, 32: tx history depth in bits (power of two); offsets 0..DEPTH-1 are searchable.
- SYNC_LEN, 16: consecutive error-free compares required to declare lock.
- WIN, 64: compares per loss-detection window while locked.
- LOSS_THR, 8: errors within one window that force loss of sync.
- CW, 16: width of bit_count and err_count.

Ports:
- clk  input  1  clock
- rst  input  1  reset (asynchronous, active-low)
- tx_valid  input  1  tx_bit is a new encoder input bit
- tx_bit  input  1  bit presented to the encoder
- rx_valid  input  1  rx_bit is a new decoder output bit
- rx_bit  input  1  decoder output bit
- clear  input  1  synchronous clear of bit_count, err_count, loss_count
- locked  output  1  alignment found, counting active
- offset  output  $clog2(DEPTH)  current or locked alignment offset
- bit_count  output  CW  compares made while locked (saturating)
- err_count  output  CW  mismatches while locked (saturating)
- loss_count  output  8  number of sync losses (saturating)
- sync_loss  output  1  one-cycle pulse on LOCKED→SEARCH

Behaviour:

Reset (rst=0, asynchronous):
- State SEARCH; wr_ptr=0; offset=0; locked=0; all counters, match_run and window counters 0; sync_loss=0.
- History contents are don't-care.

History buffer:
- On tx_valid, tx_bit is written at wr_ptr; wr_ptr increments modulo DEPTH.
- A compare on an rx_valid cycle reads hist[wr_ptr-1-offset] (mod DEPTH) using wr_ptr before any same-cycle write.
- Offset L therefore means the decoded bit matches the bit written L writes before the most recent one.
- Compares start only after at least DEPTH writes (a fill flag is set once wr_ptr wraps). rx_valid before fill is ignored.

SEARCH state:
- Each rx_valid compare: on match, match_run++; on mismatch, match_run=0 and offset++ (wrapping DEPTH-1→0).
- When match_run reaches SYNC_LEN, go to LOCKED next cycle with locked=1.
- On entry to LOCKED: offset frozen, window counters cleared.
- The compares made during search are not counted.

LOCKED state:
- Each rx_valid: bit_count++, and err_count++ on mismatch.
- Both counters saturate at all-ones.
- win_cnt counts compares; win_err counts mismatches in the current window.
- When win_err reaches LOSS_THR (the compare that makes it equal), the next cycle does all of the following:
  - state SEARCH, locked=0, sync_loss=1 for one cycle;
  - loss_count++ (saturating at 255);
  - match_run=0, offset=offset+1 (mod DEPTH).
- When win_cnt reaches WIN without loss, win_cnt and win_err are cleared and a new window starts.

clear:
- Zeroes bit_count, err_count and loss_count only.
- clear wins over a same-cycle increment.
- Does not affect state, offset or history.

Other rules:
- tx_valid and rx_valid may be asserted in the same cycle. Write and read are independent; the read sees the pre-write buffer.
- Outputs are registered; counter updates are visible the cycle after the compare.

Test Plan:
1. Reset check: assert rst=0 mid-stream → immediately locked=0, offset=0, all counts 0, sync_loss=0; deassert → SEARCH, fill restarts.
2. Clean lock: random tx stream, with rx modelled as tx delayed by 9 writes and tx_valid=rx_valid every cycle → locked=1, offset=9. After a further 1000 compares: bit_count=1000, err_count=0, loss_count=0.
3. Sparse errors: after lock, flip rx_bit on 2 compares within one 64-compare window → err_count=2, locked stays 1, no sync_loss.
4. Loss and relock: flip 8 rx bits within one window → sync_loss pulses exactly 1 cycle, locked=0, loss_count=1. With a clean stream afterwards → relock at offset=9 with bit_count continuing from its prior value.
5. Search wrap and boundary offsets: rx delayed by 31 writes → locked with offset=31. Uncorrelated random rx → locked never asserts and offset keeps cycling 0..31.
6. Saturation and clear: CW=4 build, lock, 20 mismatching compares in separate windows → err_count=15 held. Pulse clear together with rx_valid → bit_count=0, err_count=0, loss_count=0 next cycle, locked unchanged.
